// File: rtl/ip4_rtl_spa_pipe.sv
// ip4_rtl_spa_pipe: stream processor array datapath.
// Issued vector commands pass through PIPE_DEPTH delay stages (register read),
// are executed across NUM_LANE lanes into the first of EXE_STAGES execute
// stages, and leave through a valid/ready result port.
//
// Handshake: a command transfers on in_valid && in_ready. A result transfers on
// out_valid && out_ready. The whole pipe moves as one unit. It stalls only
// while a result is waiting (out_valid && !out_ready), so in_ready is simply the
// global advance signal. Bubbles are kept, never collapsed.
module ip4_rtl_spa_pipe #(
  parameter int NUM_LANE   = 8,
  parameter int WORD_W     = 32,
  parameter int PIPE_DEPTH = 3,
  parameter int EXE_STAGES = 2,
  parameter int OPC_W      = 4
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            flush,
  input  logic                                            in_valid,
  output logic                                            in_ready,
  input  logic [OPC_W-1:0]                                in_opcode,
  input  logic [NUM_LANE-1:0]                             in_mask,
  input  logic [7:0]                                      in_tag,
  input  logic [NUM_LANE*WORD_W-1:0]                      in_op_a,
  input  logic [NUM_LANE*WORD_W-1:0]                      in_op_b,
  output logic                                            out_valid,
  input  logic                                            out_ready,
  output logic [7:0]                                      out_tag,
  output logic [NUM_LANE-1:0]                             out_mask,
  output logic [NUM_LANE*WORD_W-1:0]                      out_res,
  output logic [NUM_LANE-1:0]                             out_carry,
  output logic [$clog2(PIPE_DEPTH+EXE_STAGES+1)-1:0]      occupancy
);

  localparam int L     = PIPE_DEPTH + EXE_STAGES;
  localparam int OCC_W = $clog2(L + 1);
  localparam int SH_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int DW    = NUM_LANE * WORD_W;

  localparam logic [OPC_W-1:0] OP_ADD   = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_SUB   = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_AND   = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_OR    = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_XOR   = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_SHL   = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_SHR   = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_MIN   = OPC_W'(7);
  localparam logic [OPC_W-1:0] OP_MAX   = OPC_W'(8);
  localparam logic [OPC_W-1:0] OP_PASSA = OPC_W'(9);

  // Delay (register read) stages.
  logic                d_valid [PIPE_DEPTH];
  logic [OPC_W-1:0]    d_opc   [PIPE_DEPTH];
  logic [NUM_LANE-1:0] d_mask  [PIPE_DEPTH];
  logic [7:0]          d_tag   [PIPE_DEPTH];
  logic [DW-1:0]       d_a     [PIPE_DEPTH];
  logic [DW-1:0]       d_b     [PIPE_DEPTH];

  // Execute stages; stage 0 captures the lane results, the rest only delay.
  logic                e_valid [EXE_STAGES];
  logic [NUM_LANE-1:0] e_mask  [EXE_STAGES];
  logic [7:0]          e_tag   [EXE_STAGES];
  logic [DW-1:0]       e_res   [EXE_STAGES];
  logic [NUM_LANE-1:0] e_carry [EXE_STAGES];

  logic                adv;
  logic                accept;
  logic                out_fire;
  logic [DW-1:0]       exe_res;
  logic [NUM_LANE-1:0] exe_carry;
  logic [OCC_W-1:0]    occ;

  // The only reason to hold is a result the consumer has not taken yet.
  assign adv      = !(out_valid && !out_ready);
  assign in_ready = adv;
  assign accept   = in_valid && adv;
  assign out_fire = out_valid && out_ready;

  assign out_valid = e_valid[EXE_STAGES-1];
  assign out_tag   = e_tag[EXE_STAGES-1];
  assign out_mask  = e_mask[EXE_STAGES-1];
  assign out_res   = e_res[EXE_STAGES-1];
  assign out_carry = e_carry[EXE_STAGES-1];
  assign occupancy = occ;

  // One lane of the execute unit: returns {carry, result}.
  function automatic logic [WORD_W:0] lane_op(
    input logic [OPC_W-1:0]  opc,
    input logic [WORD_W-1:0] a,
    input logic [WORD_W-1:0] b
  );
    logic [WORD_W:0]   sum;
    logic [WORD_W-1:0] r;
    logic              c;
    sum = {1'b0, a} + {1'b0, b};
    r   = '0;
    c   = 1'b0;
    case (opc)
      OP_ADD: begin
        r = sum[WORD_W-1:0];
        c = sum[WORD_W];
      end
      OP_SUB: begin
        r = a - b;
        c = (a < b);
      end
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_XOR:   r = a ^ b;
      OP_SHL:   r = a << b[SH_W-1:0];
      OP_SHR:   r = a >> b[SH_W-1:0];
      OP_MIN:   r = (a < b) ? a : b;
      OP_MAX:   r = (a > b) ? a : b;
      OP_PASSA: r = a;
      default: begin
        r = '0;
        c = 1'b0;
      end
    endcase
    return {c, r};
  endfunction

  // Execute all lanes from the last delay stage; masked-off lanes give 0/0.
  always_comb begin
    exe_res   = '0;
    exe_carry = '0;
    for (int l = 0; l < NUM_LANE; l++) begin
      if (d_mask[PIPE_DEPTH-1][l]) begin
        {exe_carry[l], exe_res[l*WORD_W +: WORD_W]} =
          lane_op(d_opc[PIPE_DEPTH-1],
                  d_a[PIPE_DEPTH-1][l*WORD_W +: WORD_W],
                  d_b[PIPE_DEPTH-1][l*WORD_W +: WORD_W]);
      end
    end
  end

  // Delay stages: reset zeroes everything, flush only drops valid bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        d_valid[i] <= 1'b0;
        d_opc[i]   <= '0;
        d_mask[i]  <= '0;
        d_tag[i]   <= '0;
        d_a[i]     <= '0;
        d_b[i]     <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        d_valid[i] <= 1'b0;
      end
    end else if (adv) begin
      d_valid[0] <= accept;
      d_opc[0]   <= in_opcode;
      d_mask[0]  <= in_mask;
      d_tag[0]   <= in_tag;
      d_a[0]     <= in_op_a;
      d_b[0]     <= in_op_b;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        d_valid[i] <= d_valid[i-1];
        d_opc[i]   <= d_opc[i-1];
        d_mask[i]  <= d_mask[i-1];
        d_tag[i]   <= d_tag[i-1];
        d_a[i]     <= d_a[i-1];
        d_b[i]     <= d_b[i-1];
      end
    end
  end

  // Execute stages: stage 0 registers lane results, later stages delay them.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < EXE_STAGES; i++) begin
        e_valid[i] <= 1'b0;
        e_mask[i]  <= '0;
        e_tag[i]   <= '0;
        e_res[i]   <= '0;
        e_carry[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < EXE_STAGES; i++) begin
        e_valid[i] <= 1'b0;
      end
    end else if (adv) begin
      e_valid[0] <= d_valid[PIPE_DEPTH-1];
      e_mask[0]  <= d_mask[PIPE_DEPTH-1];
      e_tag[0]   <= d_tag[PIPE_DEPTH-1];
      e_res[0]   <= exe_res;
      e_carry[0] <= exe_carry;
      for (int i = 1; i < EXE_STAGES; i++) begin
        e_valid[i] <= e_valid[i-1];
        e_mask[i]  <= e_mask[i-1];
        e_tag[i]   <= e_tag[i-1];
        e_res[i]   <= e_res[i-1];
        e_carry[i] <= e_carry[i-1];
      end
    end
  end

  // In-flight count: up on accept, down on result handshake, cleared by flush.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      occ <= '0;
    end else begin
      case ({accept, out_fire})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule
